// File: rtl/multi_wave_gen.sv
// Time-multiplexed multi-channel waveform generator: per-channel phase accumulators,
// one shared sine table, signed amplitude scaling, and a saturating channel mixer.

module sinetable (
    input  logic        [13:0] addr,
    output logic signed [11:0] value
);
    logic [12:0] x;
    logic [4:0]  k;
    logic [7:0]  frac;
    logic [11:0] lo;
    logic [11:0] hi;
    logic [11:0] diff;
    logic [19:0] prod;
    logic [11:0] mag;

    function automatic logic [11:0] quarter(input logic [4:0] idx);
        case (idx)
            5'd0:    quarter = 12'd0;
            5'd1:    quarter = 12'd201;
            5'd2:    quarter = 12'd399;
            5'd3:    quarter = 12'd594;
            5'd4:    quarter = 12'd783;
            5'd5:    quarter = 12'd965;
            5'd6:    quarter = 12'd1137;
            5'd7:    quarter = 12'd1299;
            5'd8:    quarter = 12'd1447;
            5'd9:    quarter = 12'd1582;
            5'd10:   quarter = 12'd1702;
            5'd11:   quarter = 12'd1805;
            5'd12:   quarter = 12'd1891;
            5'd13:   quarter = 12'd1959;
            5'd14:   quarter = 12'd2008;
            5'd15:   quarter = 12'd2037;
            default: quarter = 12'd2047;
        endcase
    endfunction

    // Quarter-wave table with linear interpolation; upper address bits select mirror and sign.
    always_comb begin
        x     = addr[12] ? (13'd4096 - {1'b0, addr[11:0]}) : {1'b0, addr[11:0]};
        k     = x[12:8];
        frac  = x[7:0];
        lo    = quarter(k);
        hi    = quarter(k + 5'd1);
        diff  = hi - lo;
        prod  = 20'(diff) * 20'(frac);
        mag   = lo + 12'(prod >> 8);
        value = addr[13] ? -$signed(mag) : $signed(mag);
    end
endmodule

module multi_wave_gen #(
    parameter int NCH   = 4,
    parameter int OUT_W = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  sample_tick,
    input  logic                                  sync,
    input  logic                                  cfg_we,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [1:0]                            cfg_addr,
    input  logic [15:0]                           cfg_data,
    output logic signed [OUT_W-1:0]               out_sample,
    output logic                                  out_valid,
    output logic                                  busy,
    output logic                                  overrun
);
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int ACC_W = 18 + $clog2(NCH);
    localparam int CW    = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
    localparam logic signed [CW-1:0] MAX_V = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CW-1:0] MIN_V = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic        [15:0] phase     [NCH];
    logic        [15:0] phase_add [NCH];
    logic        [15:0] phase_off [NCH];
    logic signed [15:0] amp       [NCH];
    logic        [1:0]  mode      [NCH];

    logic        [CH_W-1:0]  slot;
    logic signed [ACC_W-1:0] acc;
    logic                    sync_pend;
    logic                    overrun_r;
    logic signed [OUT_W-1:0] sample_r;

    logic        [15:0]      cur_phase;
    logic        [1:0]       cur_mode;
    logic signed [15:0]      cur_amp;
    logic signed [11:0]      sine_val;
    logic signed [15:0]      wave;
    logic signed [31:0]      product;
    logic signed [16:0]      term;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [CW-1:0]    acc_ext;
    logic signed [OUT_W-1:0] sample_next;
    logic                    last_slot;
    logic                    reload;

    assign cur_phase = phase[slot];
    assign cur_mode  = mode[slot];
    assign cur_amp   = amp[slot];
    assign last_slot = (slot == CH_W'(NCH - 1));
    assign reload    = (state == IDLE) && (sync || sync_pend);

    sinetable u_sine (
        .addr  (cur_phase[15:2]),
        .value (sine_val)
    );

    always_comb begin
        case (cur_mode)
            2'd0:    wave = {sine_val, 4'b0000};
            2'd1:    wave = cur_phase[15] ? -16'sd32767 : 16'sd32767;
            2'd2:    wave = {~cur_phase[15], cur_phase[14:0]};
            default: wave = '0;
        endcase
        product = $signed({{16{wave[15]}}, wave}) * $signed({{16{cur_amp[15]}}, cur_amp});
        term    = 17'(product >>> 15);
        acc_sum = acc + {{(ACC_W-17){term[16]}}, term};
        acc_ext = {{(CW-ACC_W){acc_sum[ACC_W-1]}}, acc_sum};
        if (acc_ext > MAX_V) begin
            sample_next = MAX_V[OUT_W-1:0];
        end else if (acc_ext < MIN_V) begin
            sample_next = MIN_V[OUT_W-1:0];
        end else begin
            sample_next = acc_ext[OUT_W-1:0];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sample_tick && !sync && !sync_pend) state_next = RUN;
            RUN:     if (last_slot) state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            slot      <= '0;
            acc       <= '0;
            sync_pend <= 1'b0;
            overrun_r <= 1'b0;
            sample_r  <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                phase[i]     <= '0;
                phase_add[i] <= '0;
                phase_off[i] <= '0;
                amp[i]       <= '0;
                mode[i]      <= 2'd3;
            end
        end else begin
            state <= state_next;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (cfg_we && cfg_ch == CH_W'(i)) begin
                    case (cfg_addr)
                        2'd0:    phase_add[i] <= cfg_data;
                        2'd1:    phase_off[i] <= cfg_data;
                        2'd2:    amp[i]       <= cfg_data;
                        default: mode[i]      <= cfg_data[1:0];
                    endcase
                end
                if (reload) begin
                    phase[i] <= phase_off[i];
                end else if (state == RUN && slot == CH_W'(i)) begin
                    phase[i] <= phase[i] + phase_add[i];
                end
            end
            if (state == IDLE) begin
                slot <= '0;
                acc  <= '0;
                if (reload) sync_pend <= 1'b0;
            end else begin
                if (sync) sync_pend <= 1'b1;
                if (sample_tick) overrun_r <= 1'b1;
            end
            if (state == RUN) begin
                acc  <= acc_sum;
                slot <= slot + CH_W'(1);
                // Result is registered on the edge into OUT so it is visible alongside out_valid.
                if (last_slot) sample_r <= sample_next;
            end
        end
    end

    assign out_sample = sample_r;
    assign out_valid  = (state == OUT) && !reset;
    assign busy       = (state != IDLE) && !reset;
    assign overrun    = overrun_r;
endmodule
